// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 channel mux.
// A grant holds sel stable until done, request drop, or MAX_HOLD expiry; one dead cycle always follows.
//   state | meaning
//   IDLE  | no grant; sel holds last value, sel_valid=0; picks next winner from ptr
//   GRANT | sel/grant frozen, hcnt counts held cycles until a release cause is sampled
module rr_mux_select_arbiter #(
  parameter  int MAX_HOLD = 16,
  localparam int HCW      = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic [3:0] grant,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic [3:0]       grant_q, grant_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;

  logic [1:0]       win;
  logic [1:0]       cand;
  logic             rel_done, rel_drop, rel_hold;

  always_comb begin
    // Walk offsets from far to near so the source closest to ptr wins last.
    win  = ptr_q;
    cand = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) win = cand;
    end
  end

  assign rel_done = done;
  assign rel_drop = ~req[sel_q];
  assign rel_hold = (hcnt_q == HCW'(MAX_HOLD - 1));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    grant_d     = grant_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          sel_d       = win;
          sel_valid_d = 1'b1;
          grant_d     = 4'b0001 << win;
          hcnt_d      = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_d     = IDLE;
          sel_valid_d = 1'b0;
          grant_d     = 4'b0000;
          ptr_d       = sel_q + 2'd1;
          // Only flag a forced release when nothing else ended the grant.
          timeout_d   = rel_hold & ~rel_done & ~rel_drop;
        end else begin
          hcnt_d = hcnt_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'b00;
      sel_valid_q <= 1'b0;
      grant_q     <= 4'b0000;
      timeout_q   <= 1'b0;
      ptr_q       <= 2'b00;
      hcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hcnt_q      <= hcnt_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign grant     = grant_q;
  assign timeout   = timeout_q;

endmodule
